// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one shift level per stage, valid/ready on both sides, tag pass-through.
// Optional rotate-right support is enabled by defining PIPELINED_BARREL_SHIFTER_ROTATE_EN.
module pipelined_barrel_shifter #(
    parameter int unsigned N     = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_data,
    input  logic [$clog2(N)-1:0] in_shamt,
    input  logic [1:0]           in_op,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int unsigned LEVELS = $clog2(N);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
    localparam logic [1:0] OP_ROR = 2'b11;
`endif

    // Stage registers
    logic [LEVELS-1:0] valid_q, valid_d;
    logic [N-1:0]      data_q  [LEVELS];
    logic [N-1:0]      data_d  [LEVELS];
    logic [LEVELS-1:0] shamt_q [LEVELS];
    logic [LEVELS-1:0] shamt_d [LEVELS];
    logic [1:0]        op_q    [LEVELS];
    logic [1:0]        op_d    [LEVELS];
    logic              sign_q  [LEVELS];
    logic              sign_d  [LEVELS];
    logic [TAG_W-1:0]  tag_q   [LEVELS];
    logic [TAG_W-1:0]  tag_d   [LEVELS];

    // Values presented to each stage by its upstream neighbour
    logic [LEVELS-1:0] up_valid;
    logic [N-1:0]      up_data  [LEVELS];
    logic [LEVELS-1:0] up_shamt [LEVELS];
    logic [1:0]        up_op    [LEVELS];
    logic              up_sign  [LEVELS];
    logic [TAG_W-1:0]  up_tag   [LEVELS];

    logic [LEVELS:0]   stage_ready;

    // One level of the shifter: shift by 2^k with the fill rule of the selected mode.
    function automatic logic [N-1:0] shift_level(
        input logic [N-1:0] d,
        input logic [1:0]   op,
        input logic         sign,
        input int           k
    );
        int unsigned  s;
        logic [N-1:0] fill;
        logic [N-1:0] r;
        s    = 32'd1 << k;
        fill = ~({N{1'b1}} >> s);
        case (op)
            OP_SLL:  r = d << s;
            OP_SRA:  r = (d >> s) | (sign ? fill : '0);
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
            OP_ROR:  r = (d >> s) | (d << (N - s));
`endif
            default: r = d >> s;
        endcase
        return r;
    endfunction

    // Ready chain runs combinationally from the output back to the input.
    always_comb begin
        stage_ready[LEVELS] = out_ready;
        for (int k = int'(LEVELS) - 1; k >= 0; k--) begin
            stage_ready[k] = !valid_q[k] || stage_ready[k + 1];
        end
    end

    always_comb begin
        up_valid[0] = in_valid;
        up_data[0]  = in_data;
        up_shamt[0] = in_shamt;
        up_op[0]    = in_op;
        up_sign[0]  = in_data[N-1];
        up_tag[0]   = in_tag;
        for (int k = 1; k < int'(LEVELS); k++) begin
            up_valid[k] = valid_q[k - 1];
            up_data[k]  = data_q[k - 1];
            up_shamt[k] = shamt_q[k - 1];
            up_op[k]    = op_q[k - 1];
            up_sign[k]  = sign_q[k - 1];
            up_tag[k]   = tag_q[k - 1];
        end
    end

    // Stalled stages hold; payload only moves alongside a valid request.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        op_d    = op_q;
        sign_d  = sign_q;
        tag_d   = tag_q;
        for (int k = 0; k < int'(LEVELS); k++) begin
            if (stage_ready[k]) begin
                valid_d[k] = up_valid[k];
                if (up_valid[k]) begin
                    data_d[k]  = up_shamt[k][k]
                               ? shift_level(up_data[k], up_op[k], up_sign[k], k)
                               : up_data[k];
                    shamt_d[k] = up_shamt[k];
                    op_d[k]    = up_op[k];
                    sign_d[k]  = up_sign[k];
                    tag_d[k]   = up_tag[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < int'(LEVELS); k++) begin
                data_q[k]  <= '0;
                shamt_q[k] <= '0;
                op_q[k]    <= '0;
                sign_q[k]  <= 1'b0;
                tag_q[k]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            tag_q   <= tag_d;
        end
    end

    assign in_ready  = stage_ready[0];
    assign out_valid = valid_q[LEVELS-1];
    assign out_data  = data_q[LEVELS-1];
    assign out_tag   = tag_q[LEVELS-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (N=32, TAG_W=4) against an arithmetic reference model.
module tb_pipelined_barrel_shifter;

    localparam int N      = 32;
    localparam int TAG_W  = 4;
    localparam int LEVELS = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic [4:0]       in_shamt;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    int errors;
    int checks;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] d;
        int          sh;
        logic [31:0] e;
    } vec_t;

    pipelined_barrel_shifter #(.N(N), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Whole-word reference: plain shift operators over the full amount.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh, input logic [1:0] op);
        logic [31:0] r;
        case (op)
            2'b00:   r = d << sh;
            2'b01:   r = d >> sh;
            2'b10:   r = 32'($signed(d) >>> sh);
            default: begin
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
                r = (sh == 0) ? d : ((d >> sh) | (d << (32 - sh)));
`else
                r = d >> sh;
`endif
            end
        endcase
        return r;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        vec_t v[$];
        int cyc;
        logic [3:0] t;
        v.push_back('{2'b00, 32'h0000_0001, 31, 32'h8000_0000});
        v.push_back('{2'b10, 32'h8000_0000, 4, 32'hF800_0000});
        v.push_back('{2'b10, 32'h7000_0000, 4, 32'h0700_0000});
        v.push_back('{2'b01, 32'hDEAD_BEEF, 8, 32'h00DE_ADBE});
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
        v.push_back('{2'b11, 32'h0000_00F1, 4, 32'h1000_000F});
`else
        v.push_back('{2'b11, 32'h0000_00F1, 4, 32'h0000_000F});
`endif
        for (int m = 0; m < 4; m++) v.push_back('{2'(m), 32'hA5C3_1E7F, 0, 32'hA5C3_1E7F});
        for (int i = 0; i < v.size(); i++) begin
            t = 4'(i + 3);
            @(negedge clk);
            in_valid = 1'b1; in_data = v[i].d; in_shamt = 5'(v[i].sh); in_op = v[i].op; in_tag = t;
            out_ready = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL directed_accept[%0d]: in_ready=%b want 1", i, in_ready); end
            @(posedge clk);
            cyc = 0;
            do begin
                @(negedge clk); in_valid = 1'b0; #1; cyc++;
            end while (out_valid !== 1'b1 && cyc < 20);
            checks++; if (out_valid !== 1'b1 || cyc != LEVELS) begin errors++; $display("FAIL directed_latency[%0d]: got %0d cycles want %0d", i, cyc, LEVELS); end
            checks++; if (out_data !== v[i].e) begin errors++; $display("FAIL directed_data[%0d]: got %h want %h", i, out_data, v[i].e); end
            checks++; if (out_tag !== t) begin errors++; $display("FAIL directed_tag[%0d]: got %h want %h", i, out_tag, t); end
            @(posedge clk);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] d [8];
        logic [4:0]  s [8];
        logic [1:0]  o [8];
        int acc;
        for (int i = 0; i < 8; i++) begin
            d[i] = $urandom; s[i] = 5'($urandom_range(1, 31)); o[i] = 2'($urandom_range(0, 3));
        end
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid = (acc < 8);
            if (acc < 8) begin in_data = d[acc]; in_shamt = s[acc]; in_op = o[acc]; in_tag = 4'(acc); end
            #1;
            if (in_valid && in_ready) acc++;
        end
        checks++; if (acc != LEVELS) begin errors++; $display("FAIL bp_accepted: got %0d want %0d", acc, LEVELS); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid_full: got %b want 1", out_valid); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (acc < 8);
            if (acc < 8) begin in_data = d[acc]; in_shamt = s[acc]; in_op = o[acc]; in_tag = 4'(acc); end
            #1;
            if (in_valid && in_ready) acc++;
            checks++;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_gap[%0d]: out_valid=%b want 1", c, out_valid);
            end else if (out_tag !== 4'(c) || out_data !== ref_shift(d[c], int'(s[c]), o[c])) begin
                errors++; $display("FAIL bp_result[%0d]: got tag %h data %h want tag %h data %h",
                                   c, out_tag, out_data, 4'(c), ref_shift(d[c], int'(s[c]), o[c]));
            end
        end
        checks++; if (acc != 8) begin errors++; $display("FAIL bp_total_accepted: got %0d want 8", acc); end
        @(posedge clk);
    endtask

    task automatic test_stream(input bit rnd);
        logic [31:0] eq_d[$];
        logic [3:0]  eq_t[$];
        int sent, recv, cyc;
        bit last_acc;
        sent = 0; recv = 0; cyc = 0; last_acc = 1'b0;
        in_valid = 1'b0;
        while (recv < 100 && cyc < 3000) begin
            @(negedge clk);
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (!(in_valid && !last_acc)) begin
                if (sent < 100 && (!rnd || $urandom_range(0, 3) != 0)) begin
                    in_valid = 1'b1; in_data = $urandom; in_shamt = 5'($urandom_range(0, 31));
                    in_op = 2'($urandom_range(0, 3)); in_tag = 4'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            #1;
            last_acc = in_valid && in_ready;
            if (last_acc) begin
                eq_d.push_back(ref_shift(in_data, int'(in_shamt), in_op));
                eq_t.push_back(in_tag);
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (eq_d.size() == 0) begin
                    errors++; $display("FAIL stream_spurious: tag %h data %h with nothing outstanding", out_tag, out_data);
                end else begin
                    if (out_data !== eq_d[0] || out_tag !== eq_t[0]) begin
                        errors++; $display("FAIL stream_result[%0d]: got tag %h data %h want tag %h data %h",
                                           recv, out_tag, out_data, eq_t[0], eq_d[0]);
                    end
                    void'(eq_d.pop_front()); void'(eq_t.pop_front());
                end
                if (!rnd) begin
                    checks++;
                    if (cyc != LEVELS + recv) begin errors++; $display("FAIL stream_timing[%0d]: at cycle %0d want %0d", recv, cyc, LEVELS + recv); end
                end
                recv++;
            end
            cyc++;
        end
        checks++; if (recv != 100) begin errors++; $display("FAIL stream_count: got %0d want 100", recv); end
        @(posedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midstream;
        int cyc;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid = 1'b1; in_data = 32'h1234_5670 + 32'(i); in_shamt = 5'(i); in_op = 2'b00; in_tag = 4'(10 + i);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_fill_accept[%0d]: in_ready=%b want 1", i, in_ready); end
        end
        @(negedge clk); in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL mid_rst_data: got %h want 0", out_data); end
        checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL mid_rst_tag: got %h want 0", out_tag); end
        in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_shamt = 5'd1; in_op = 2'b00; in_tag = 4'hE; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        in_data = 32'hF000_000F; in_shamt = 5'd3; in_op = 2'b01; in_tag = 4'h5;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_post_accept: in_ready=%b want 1", in_ready); end
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk); in_valid = 1'b0; #1; cyc++;
        end while (out_valid !== 1'b1 && cyc < 20);
        checks++; if (out_valid !== 1'b1 || cyc != LEVELS) begin errors++; $display("FAIL mid_post_latency: got %0d cycles want %0d", cyc, LEVELS); end
        checks++; if (out_data !== 32'h1E00_0001) begin errors++; $display("FAIL mid_post_data: got %h want 1e000001", out_data); end
        checks++; if (out_tag !== 4'h5) begin errors++; $display("FAIL mid_post_tag: got %h want 5", out_tag); end
        @(posedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset;
        test_directed;
        test_backpressure;
        test_stream(1'b0);
        test_stream(1'b1);
        test_reset_midstream;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
